psum_collector: RTL and testbench

PSUM_COLLECTOR -- requirements
Module: psum_collector

---
 rtl/psum_pkg.sv | 14 +
 rtl/psum_col_fifo.sv | 63 ++++++
 rtl/psum_collector.sv | 66 ++++++
 tb/tb_psum_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared defaults and sizing helpers for the partial-sum collector.
package psum_pkg;
  localparam int unsigned COL_DEFAULT     = 8;
  localparam int unsigned PSUM_BW_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT   = 8;

  function automatic int unsigned ptr_width(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/psum_col_fifo.sv
// One column of the collector: circular buffer with pointers and occupancy count.
module psum_col_fifo
  import psum_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW_DEFAULT,
  parameter int unsigned depth   = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [psum_bw-1:0] data_i,
  output logic [psum_bw-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int unsigned PW = ptr_width(depth);
  localparam int unsigned CW = cnt_width(depth);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [psum_bw-1:0] mem_q [depth];
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CW'(depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full column still accepts a write when its head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; the top masks it whenever no full row exists.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/psum_collector.sv
// Collects skewed south-edge partial sums into complete rows, one FIFO per column.
// Optional sticky overflow flag o_err is built when PSUM_COLLECTOR_ERR_EN is defined.
module psum_collector
  import psum_pkg::*;
#(
  parameter int unsigned col     = COL_DEFAULT,
  parameter int unsigned psum_bw = PSUM_BW_DEFAULT,
  parameter int unsigned depth   = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
`ifdef PSUM_COLLECTOR_ERR_EN
  output logic                   o_err,
`endif
  output logic                   o_ready
);
  logic [col-1:0]         full;
  logic [col-1:0]         empty;
  logic [psum_bw*col-1:0] head;
  logic                   pop;

  // Handshake: a row transfers on a rising edge where rd=1 and o_valid=1; rd while
  // o_valid=0 is ignored. o_ready only advises that no column is full.
  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd && o_valid;
  assign out     = o_valid ? head : '0;

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_col_fifo #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (wr[c]),
      .pop_i  (pop),
      .data_i (in[c*psum_bw +: psum_bw]),
      .data_o (head[c*psum_bw +: psum_bw]),
      .full_o (full[c]),
      .empty_o(empty[c])
    );
  end

`ifdef PSUM_COLLECTOR_ERR_EN
  logic err_q, err_d;
  logic drop;

  // Pop is row-wide, so a strobe into a full column drops only when no pop happens.
  assign drop  = (|(wr & full)) && !pop;
  assign err_d = err_q | drop;
  assign o_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif
endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: vector table plus scoreboarded corner sequences.
module tb_psum_collector;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int RW  = COL * BW;

  logic          clk;
  logic          reset;
  logic [RW-1:0] in_r;
  logic [7:0]    wr_r;
  logic          rd_r;
  logic [RW-1:0] out;
  logic          o_valid;
  logic          o_full;
  logic          o_ready;
`ifdef PSUM_COLLECTOR_ERR_EN
  logic          o_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [7:0]    wr;
    logic [RW-1:0] data;
    logic          rd;
    logic          exp_valid;
    logic          exp_full;
    logic [RW-1:0] exp_out;
  } vec_t;

  vec_t vecs[12];

  psum_collector dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in_r),
    .wr     (wr_r),
    .rd     (rd_r),
    .out    (out),
    .o_valid(o_valid),
    .o_full (o_full),
`ifdef PSUM_COLLECTOR_ERR_EN
    .o_err  (o_err),
`endif
    .o_ready(o_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom_range(0, 16'hFFFF));
    return r;
  endfunction

  // driver tasks
  task automatic push_row(input logic [RW-1:0] d);
    wr_r = 8'hFF;
    in_r = d;
    exp_q.push_back(d);
    step();
    wr_r = '0;
  endtask

  task automatic pop_row(input string tag);
    logic [RW-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got out %h", tag, out);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, RW'(o_valid), RW'(1));
      chk({tag, "_data"}, out, e);
    end
    rd_r = 1'b1;
    step();
    rd_r = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic f);
    chk({tag, "_valid"}, RW'(o_valid), RW'(v));
    chk({tag, "_full"},  RW'(o_full),  RW'(f));
    chk({tag, "_ready"}, RW'(o_ready), RW'(!f));
  endtask

  initial begin
    logic [RW-1:0] row_seq, row_skew, x, y, e;
    reset = 1'b0;
    in_r  = '0;
    wr_r  = '0;
    rd_r  = 1'b0;
    step();
    do_reset();
    chk_flags("reset", 1'b0, 1'b0);
    chk("reset_out", out, '0);

    for (int c = 0; c < COL; c++) begin
      row_seq[c*BW +: BW]  = BW'(c + 1);
      row_skew[c*BW +: BW] = BW'(16'hA0 + c);
    end
    vecs[0] = '{wr: 8'hFF, data: row_seq, rd: 1'b0, exp_valid: 1'b1, exp_full: 1'b0, exp_out: row_seq};
    vecs[1] = '{wr: 8'h00, data: '0, rd: 1'b1, exp_valid: 1'b0, exp_full: 1'b0, exp_out: '0};
    for (int c = 0; c < COL; c++)
      vecs[2+c] = '{wr: 8'(1 << c), data: row_skew, rd: 1'b0, exp_valid: (c == 7),
                    exp_full: 1'b0, exp_out: (c == 7) ? row_skew : '0};
    vecs[10] = '{wr: 8'h00, data: '0, rd: 1'b1, exp_valid: 1'b0, exp_full: 1'b0, exp_out: '0};
    vecs[11] = '{wr: 8'h00, data: '0, rd: 1'b1, exp_valid: 1'b0, exp_full: 1'b0, exp_out: '0};

    for (int i = 0; i < 12; i++) begin
      wr_r = vecs[i].wr;
      in_r = vecs[i].data;
      rd_r = vecs[i].rd;
      step();
      chk_flags($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_full);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
    end
    wr_r = '0;
    rd_r = 1'b0;

    // fill then overflow
    do_reset();
    for (int r = 0; r < 8; r++) push_row(rand_row());
    chk_flags("filled", 1'b1, 1'b1);
    wr_r = 8'hFF;
    in_r = {COL{16'hDEAD}};
    step();
    wr_r = '0;
    chk_flags("overflow", 1'b1, 1'b1);
`ifdef PSUM_COLLECTOR_ERR_EN
    chk("overflow_err", RW'(o_err), RW'(1));
`endif
    for (int r = 0; r < 8; r++) pop_row($sformatf("drain%0d", r));
    chk_flags("drained", 1'b0, 1'b0);
    chk("drained_out", out, '0);
`ifdef PSUM_COLLECTOR_ERR_EN
    chk("err_sticky", RW'(o_err), RW'(1));
`endif

    // push and pop together on full columns
    do_reset();
    for (int r = 0; r < 8; r++) push_row(rand_row());
    e = exp_q.pop_front();
    chk("pp_head", out, e);
    x = rand_row();
    wr_r = 8'hFF;
    in_r = x;
    rd_r = 1'b1;
    exp_q.push_back(x);
    step();
    wr_r = '0;
    rd_r = 1'b0;
    chk_flags("pp_after", 1'b1, 1'b1);
`ifdef PSUM_COLLECTOR_ERR_EN
    chk("pp_err", RW'(o_err), RW'(0));
`endif
    for (int r = 0; r < 8; r++) pop_row($sformatf("pp_drain%0d", r));
    chk_flags("pp_empty", 1'b0, 1'b0);

    // read while the row is incomplete
    do_reset();
    x = rand_row();
    y = rand_row();
    wr_r = 8'h7F;
    in_r = x;
    step();
    wr_r = '0;
    chk_flags("partial", 1'b0, 1'b0);
    rd_r = 1'b1;
    step();
    rd_r = 1'b0;
    chk_flags("spurious_rd", 1'b0, 1'b0);
    wr_r = 8'h80;
    in_r = y;
    step();
    wr_r = '0;
    e = x;
    e[7*BW +: BW] = y[7*BW +: BW];
    exp_q.push_back(e);
    pop_row("spurious_row");
    chk_flags("spurious_done", 1'b0, 1'b0);

    // reset with rows queued, an overflow flagged and a partial row pending
    do_reset();
    for (int r = 0; r < 8; r++) push_row(rand_row());
    wr_r = 8'hFF;
    in_r = {COL{16'hDEAD}};
    step();
    for (int r = 0; r < 5; r++) pop_row($sformatf("pre_rst%0d", r));
    wr_r = 8'h0F;
    in_r = rand_row();
    step();
    reset = 1'b1;
    wr_r = 8'hFF;
    rd_r = 1'b1;
    step();
    reset = 1'b0;
    wr_r = '0;
    rd_r = 1'b0;
    exp_q.delete();
    chk_flags("mid_rst", 1'b0, 1'b0);
    chk("mid_rst_out", out, '0);
`ifdef PSUM_COLLECTOR_ERR_EN
    chk("mid_rst_err", RW'(o_err), RW'(0));
`endif
    wr_r = 8'hF0;
    in_r = rand_row();
    step();
    wr_r = '0;
    chk_flags("post_rst_partial", 1'b0, 1'b0);
    do_reset();
    push_row(rand_row());
    pop_row("post_rst_row");
    chk_flags("post_rst_done", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
